// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // One-hot result codes, bit order {gt, eq, lt}
    localparam logic [2:0] RES_LT = 3'b001;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b100;

endpackage

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational unsigned comparator for one CHUNK-bit digit.
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (x <  y);
    assign eq = (x == y);
    assign gt = (x >  y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with early termination and
// valid/ready handshakes on both sides.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(NCHUNK) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             alb,
    output logic             aeb,
    output logic             agb,
    output logic [CW-1:0]    cycles
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cycles;
    logic [2:0]       r_res;

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_lt;
    logic             w_eq;
    logic             w_gt;
    logic [WIDTH-1:0] w_sign_flip;

    // Flipping the sign bit maps two's complement onto an unsigned ordering;
    // it is applied at latch time so every chunk is then compared unsigned.
    assign w_sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    assign w_a_sh = r_a >> (int'(r_idx) * CHUNK);
    assign w_b_sh = r_b >> (int'(r_idx) * CHUNK);
    assign w_ca   = w_a_sh[CHUNK-1:0];
    assign w_cb   = w_b_sh[CHUNK-1:0];

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .x  (w_ca),
        .y  (w_cb),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_cycles <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a ^ w_sign_flip;
                        r_b      <= b ^ w_sign_flip;
                        r_idx    <= IW'(NCHUNK - 1);
                        r_cycles <= '0;
                        r_state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_cycles <= r_cycles + CW'(1);
                    if (w_lt) begin
                        r_res   <= RES_LT;
                        r_state <= DONE;
                    end else if (w_gt) begin
                        r_res   <= RES_GT;
                        r_state <= DONE;
                    end else if (w_eq && r_idx == '0) begin
                        r_res   <= RES_EQ;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_res   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_res   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign alb       = r_res[0];
    assign aeb       = r_res[1];
    assign agb       = r_res[2];
    assign cycles    = r_cycles;

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Parametrised, digit-serial magnitude comparator. It is the next generation of the team's fixed 4-bit lt/eq/gt comparator. Operands of WIDTH bits are compared MSB-first, CHUNK bits per cycle, with early termination at the first differing chunk. Signed and unsigned modes are supported. Operands enter and results leave through valid/ready handshakes, so the block can sit between a priority-encoder front end and downstream arbitration logic.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; must be 2 or greater.
NCHUNK, WIDTH/CHUNK, derived (localparam); number of chunks per operand.
CW, $clog2(NCHUNK)+1, derived (localparam); width of the cycles output.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
signed_mode  input  1  1 = two's-complement compare; 0 = unsigned compare.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
alb  output  1  A < B.
aeb  output  1  A == B.
agb  output  1  A > B.
cycles  output  CW  number of chunks examined (1..NCHUNK).

Behaviour:
- Reset: the reset is synchronous and active-low and is sampled only at a clk edge. While rst_n=0 at an edge, the state goes to IDLE and all registers clear. After reset, in_ready=1, out_valid=0, alb=aeb=agb=0 and cycles=0.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and signed_mode, set idx=NCHUNK-1, clear cycles, and go to COMPARE.
  - COMPARE: in_ready=0. Compare chunk idx of the latched A and B, increment cycles, then:
    - chunks differ: set alb or agb and go to DONE;
    - chunks equal and idx==0: set aeb and go to DONE;
    - otherwise: decrement idx and stay in COMPARE.
  - DONE: out_valid=1 and in_ready=0. The outputs alb/aeb/agb/cycles hold stable until out_ready=1, then go to IDLE. Result flags clear on leaving DONE.
- Signed mode: invert bit WIDTH-1 of both latched operands before the top chunk is compared. The lower chunks are compared unsigned.
- Result encoding: exactly one of alb/aeb/agb is 1 whenever out_valid=1. All three are 0 otherwise.
- Latency: with an acceptance edge at the end of cycle t and k chunks examined, out_valid is first high in cycle t+k+1. Minimum k=1; maximum k=NCHUNK.
- Throughput: at most one operation in flight. in_valid is ignored outside IDLE, and a/b may change freely once accepted.
- No same-cycle turnaround: the DONE-to-IDLE transition costs one cycle before the next accept.
- Reset mid-operation: the operation in flight is discarded and no out_valid pulse occurs.
- Fixed corner cases:
  - Full-scale unsigned 0 vs 2^WIDTH-1 gives alb with cycles=1.
  - Signed most-negative vs most-positive gives alb with cycles=1.

Decomposition:
- Package cmp_pkg:
  - state enum {IDLE, COMPARE, DONE};
  - localparam result-encoding constants RES_LT, RES_EQ, RES_GT as a 3-bit one-hot.
- Sub-module chunk_cmp: purely combinational, parametrised by CHUNK. Inputs x, y; outputs lt, eq, gt. It generalises the existing 4-bit comparator and is instantiated once, driven by the chunk selected by idx.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. Unsigned a=0x1234, b=0x1235, accepted in cycle t -> alb=1, cycles=4, out_valid first high in cycle t+5.
2. Unsigned a=0xF000, b=0x0FFF -> agb=1, cycles=1, out_valid high in cycle t+2.
3. Same operands as scenario 2 with signed_mode=1 -> alb=1 (-4096 < 4095), cycles=1; then a=0x8000, b=0x7FFF, signed -> alb=1, cycles=1.
4. a=b=0xABCD in each mode -> aeb=1, alb=agb=0, cycles=4.
5. Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not accepted; out_ready=1 -> IDLE next cycle, then the new pair is accepted.
6. rst_n=0 for one edge during COMPARE of a=0x0000, b=0x0001 -> next cycle IDLE, in_ready=1, out_valid=0, flags 0, and no result is ever emitted for that pair.
